// File: rtl/multi_peak_daq_pkg.sv
// Shared record layout and mode encodings for the multi-channel peak DAQ.
package multi_peak_daq_pkg;
    localparam int   REC_W    = 64;
    localparam int   CH_W     = 2;
    localparam int   BODY_W   = REC_W - CH_W;
    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Record = {ch, sample, ts}. Sample and ts arrive zero-extended to the body
    // width; ts_w tells where the sample field starts.
    function automatic logic [REC_W-1:0] rec_pack(input logic [CH_W-1:0]   ch,
                                                  input logic [BODY_W-1:0] sample,
                                                  input logic [BODY_W-1:0] ts,
                                                  input int                ts_w);
        logic [BODY_W-1:0] body;
        body = (sample << ts_w) | ts;
        return {ch, body};
    endfunction
endpackage

// File: rtl/multi_peak_daq_fifo.sv
// First-word-fall-through record FIFO. A push into a full FIFO is ignored, and
// fullness is judged on the current state, so a same-cycle pop does not make room.
module daq_sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    // Head is forced to zero while empty so nothing stale shows on the bus.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/multi_peak_daq.sv
// Multi-channel local-extremum detector feeding a record FIFO and an AXI-Stream
// packetiser with size- and timeout-based TLAST.
module multi_peak_daq
    import multi_peak_daq_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int ADC_W      = 14,
    parameter int TS_W       = 48,
    parameter int ADC_SIGNED = 1,
    parameter int FIFO_DEPTH = 1024,
    parameter int HOLDOFF_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCH*ADC_W-1:0]        adc_in,
    input  logic                        daq_enable,
    input  logic [NCH-1:0]              mode,
    input  logic [NCH*ADC_W-1:0]        threshold,
    input  logic [HOLDOFF_W-1:0]        holdoff,
    input  logic [31:0]                 packet_size,
    input  logic [15:0]                 flush_timeout,
    input  logic                        clr_stat,
    output logic [63:0]                 m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [7:0]                  m_axis_tkeep,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [31:0]                 drop_cnt,
    output logic                        overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    function automatic logic lt(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
        if (ADC_SIGNED != 0) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    logic [TS_W-1:0]            ts;
    logic [NCH-1:0]             hit, pend_vld, pend_drop, grant;
    logic [NCH-1:0][REC_W-1:0]  pend_rec;
    logic [PW-1:0]              rr_ptr, gnt_idx;
    logic                       wr_req, fifo_full, fifo_empty, push_done, accept;
    logic [2:0]                 n_drop;
    logic [31:0]                drop_base, drop_next, pkt_cnt, ps_m1;
    logic [32:0]                drop_sum;
    logic [15:0]                idle;
    logic                       flush_armed, flush_cond;

    // Free-running acquisition timestamp, frozen while acquisition is gated off.
    always_ff @(posedge clk) begin
        if (reset)           ts <= '0;
        else if (daq_enable) ts <= ts + TS_W'(1);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ADC_W-1:0]     s0, s1, s2, thr;
        logic [TS_W-1:0]      t0, t1;
        logic [HOLDOFF_W-1:0] hcnt;
        logic                 is_min, is_max, pv;
        logic [REC_W-1:0]     pr;

        assign thr       = threshold[c*ADC_W +: ADC_W];
        assign is_min    = lt(s1, thr) & lt(s1, s0) & lt(s1, s2);
        assign is_max    = lt(thr, s1) & lt(s0, s1) & lt(s2, s1);
        assign hit[c]    = ((mode[c] == MODE_MAX) ? is_max : is_min) & daq_enable & (hcnt == '0);
        // New hit is lost only if the slot stays occupied past this cycle.
        assign pend_drop[c] = hit[c] & pv & ~grant[c];
        assign pend_vld[c]  = pv;
        assign pend_rec[c]  = pr;

        // Three-sample window, each sample tagged with the ts of its arrival cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                s0 <= '0; s1 <= '0; s2 <= '0; t0 <= '0; t1 <= '0;
            end else begin
                s0 <= adc_in[c*ADC_W +: ADC_W];
                s1 <= s0;
                s2 <= s1;
                t0 <= ts;
                t1 <= t0;
            end
        end

        // Dead time after each qualified hit.
        always_ff @(posedge clk) begin
            if (reset)            hcnt <= '0;
            else if (hit[c])      hcnt <= holdoff;
            else if (hcnt != '0)  hcnt <= hcnt - HOLDOFF_W'(1);
        end

        // Single-entry pending slot; a grant frees it even when the FIFO drops it.
        always_ff @(posedge clk) begin
            if (reset) begin
                pv <= 1'b0;
                pr <= '0;
            end else if (hit[c] & (~pv | grant[c])) begin
                pv <= 1'b1;
                pr <= rec_pack(CH_W'(c), BODY_W'(s1), BODY_W'(t1), TS_W);
            end else if (grant[c]) begin
                pv <= 1'b0;
            end
        end
    end

    // Round-robin: search from rr_ptr upward first, then wrap to the low channels.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        wr_req  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!wr_req && pend_vld[c] && (PW'(c) >= rr_ptr)) begin
                wr_req = 1'b1; gnt_idx = PW'(c);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!wr_req && pend_vld[c]) begin
                wr_req = 1'b1; gnt_idx = PW'(c);
            end
        end
        for (int c = 0; c < NCH; c++) grant[c] = wr_req && (gnt_idx == PW'(c));
    end

    // Pointer moves to the channel after the last one served.
    always_ff @(posedge clk) begin
        if (reset)       rr_ptr <= '0;
        else if (wr_req) rr_ptr <= (gnt_idx == PW'(NCH-1)) ? '0 : gnt_idx + PW'(1);
    end

    daq_sync_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_req),
        .din   (pend_rec[gnt_idx]),
        .pop   (accept),
        .dout  (m_axis_tdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign push_done     = wr_req & ~fifo_full;
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tkeep  = 8'hff;
    assign accept        = m_axis_tvalid & m_axis_tready;
    assign ps_m1         = (packet_size == '0) ? '0 : packet_size - 32'd1;
    assign m_axis_tlast  = m_axis_tvalid &
                           ((pkt_cnt == ps_m1) | (flush_armed & (fifo_count == CW'(1))));
    assign flush_cond    = (flush_timeout != '0) & (idle >= flush_timeout) &
                           ((pkt_cnt != '0) | (fifo_count != '0));

    // Drops this cycle: pending-slot collisions plus a write refused by a full FIFO.
    always_comb begin
        n_drop = 3'(wr_req & fifo_full);
        for (int c = 0; c < NCH; c++) n_drop = n_drop + 3'(pend_drop[c]);
        drop_base = clr_stat ? '0 : drop_cnt;
        drop_sum  = {1'b0, drop_base} + 33'(n_drop);
        drop_next = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    // Loss statistics; a coincident drop outranks clr_stat.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            drop_cnt <= drop_next;
            overflow <= (overflow & ~clr_stat) | (n_drop != '0);
        end
    end

    // Beat counter, idle timer and flush arming for TLAST generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt     <= '0;
            idle        <= '0;
            flush_armed <= 1'b0;
        end else begin
            if (accept) pkt_cnt <= m_axis_tlast ? '0 : pkt_cnt + 32'd1;
            if (push_done)          idle <= '0;
            else if (idle != '1)    idle <= idle + 16'd1;
            if ((accept & m_axis_tlast) | push_done) flush_armed <= 1'b0;
            else if (flush_cond)                     flush_armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_peak_daq.sv
// Directed bench for multi_peak_daq: NCH=2, 14-bit samples, 16-deep FIFO.
module tb_multi_peak_daq;
    localparam int NCH = 2, ADC_W = 14, DEPTH = 16;

    logic                 clk = 1'b0, reset = 1'b1;
    logic [NCH*ADC_W-1:0] adc_in;
    logic                 daq_enable;
    logic [NCH-1:0]       mode;
    logic [NCH*ADC_W-1:0] threshold;
    logic [15:0]          holdoff;
    logic [31:0]          packet_size;
    logic [15:0]          flush_timeout;
    logic                 clr_stat;
    logic [63:0]          m_axis_tdata;
    logic                 m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [7:0]           m_axis_tkeep;
    logic [4:0]           fifo_count;
    logic [31:0]          drop_cnt;
    logic                 overflow;

    multi_peak_daq #(.NCH(NCH), .ADC_W(ADC_W), .TS_W(48), .ADC_SIGNED(1),
                     .FIFO_DEPTH(DEPTH), .HOLDOFF_W(16)) dut (
        .clk(clk), .reset(reset), .adc_in(adc_in), .daq_enable(daq_enable),
        .mode(mode), .threshold(threshold), .holdoff(holdoff),
        .packet_size(packet_size), .flush_timeout(flush_timeout), .clr_stat(clr_stat),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tkeep(m_axis_tkeep), .fifo_count(fifo_count),
        .drop_cnt(drop_cnt), .overflow(overflow));

    always #5 clk = ~clk;

    int              n_vec = 0, n_bad = 0;
    longint unsigned ts_model = 0;
    logic [64:0]     beats[$];
    logic            stalled = 1'b0;
    logic [63:0]     stall_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rec(input int ch, input int s, input longint unsigned t);
        return {2'(ch), 14'(s), 48'(t)};
    endfunction

    function automatic logic [64:0] beat(input int i);
        if (i < beats.size()) return beats[i];
        return '0;
    endfunction

    // One clock; the model timestamp follows the DUT rule (reset->0, +1 while enabled).
    task automatic tick();
        @(posedge clk);
        if (reset) ts_model = 0;
        else if (daq_enable) ts_model = ts_model + 1;
        #1;
    endtask

    task automatic step(input int a0, input int a1, output longint unsigned t);
        t = ts_model;
        adc_in = {14'(a1), 14'(a0)};
        tick();
    endtask

    // Capture accepted beats and check that a stalled head does not change.
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid) begin
            if (stalled) chk("stall_hold", m_axis_tdata, stall_data);
            if (m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
            stalled    <= !m_axis_tready;
            stall_data <= m_axis_tdata;
        end else begin
            stalled <= 1'b0;
        end
    end

    initial begin
        longint unsigned t, tn, tm, ta, tsg, tb;
        longint unsigned tt[20];
        adc_in = {14'd200, 14'd200};
        daq_enable = 1'b0; mode = '0; threshold = {14'd100, 14'd100};
        holdoff = '0; packet_size = '0; flush_timeout = '0; clr_stat = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();

        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast",  64'(m_axis_tlast), 64'd0);
        chk("rst_tdata",  m_axis_tdata, 64'd0);
        chk("rst_count",  64'(fifo_count), 64'd0);
        chk("rst_drops",  64'(drop_cnt), 64'd0);
        chk("rst_ovf",    64'(overflow), 64'd0);
        chk("tkeep",      64'(m_axis_tkeep), 64'hff);

        reset = 1'b0; daq_enable = 1'b1;
        repeat (4) step(200, 200, t);

        // 1: single minimum, exact latency, then a plateau that must not trigger
        step(90, 200, tn);
        chk("t1_n1", 64'(m_axis_tvalid), 64'd0); step(200, 200, t);
        chk("t1_n2", 64'(m_axis_tvalid), 64'd0); step(200, 200, t);
        chk("t1_n3", 64'(m_axis_tvalid), 64'd0); step(200, 200, t);
        chk("t1_n4_valid", 64'(m_axis_tvalid), 64'd1);
        chk("t1_n4_data",  m_axis_tdata, rec(0, 90, tn));
        chk("t1_n4_last",  64'(m_axis_tlast), 64'd1);
        step(200, 200, t);
        beats.delete();
        step(90, 200, t); step(90, 200, t);
        repeat (8) step(200, 200, t);
        chk("t1_plateau", 64'(beats.size()), 64'd0);

        // 1b: maximum detection on ch1
        mode = 2'b10;
        repeat (4) step(200, 50, t);
        step(200, 150, tm);
        repeat (4) step(200, 50, t);
        repeat (4) step(200, 200, t);
        mode = 2'b00;
        chk("t1b_cnt",  64'(beats.size()), 64'd1);
        chk("t1b_data", beat(0)[63:0], rec(1, 150, tm));

        // 2: simultaneous pair, lone ch0 hit (pointer -> ch1), then another pair
        beats.delete();
        step(90, 80, ta);  repeat (3) step(200, 200, t);
        step(70, 200, tsg); repeat (3) step(200, 200, t);
        step(60, 50, tb);  repeat (12) step(200, 200, t);
        chk("t2_cnt", 64'(beats.size()), 64'd5);
        chk("t2_b0",  beat(0)[63:0], rec(0, 90, ta));
        chk("t2_b1",  beat(1)[63:0], rec(1, 80, ta));
        chk("t2_b2",  beat(2)[63:0], rec(0, 70, tsg));
        chk("t2_b3",  beat(3)[63:0], rec(1, 50, tb));
        chk("t2_b4",  beat(4)[63:0], rec(0, 60, tb));

        // 3: holdoff=10 swallows the hit at +5, not the one at +12
        holdoff = 16'd10;
        beats.delete();
        for (int i = 0; i < 16; i++) begin
            step((i == 0 || i == 5 || i == 12) ? 90 : 200, 200, t);
            if (i == 0)  tt[0] = t;
            if (i == 12) tt[1] = t;
        end
        repeat (10) step(200, 200, t);
        holdoff = '0;
        chk("t3_cnt",   64'(beats.size()), 64'd2);
        chk("t3_b0",    beat(0)[63:0], rec(0, 90, tt[0]));
        chk("t3_b1",    beat(1)[63:0], rec(0, 90, tt[1]));
        chk("t3_drops", 64'(drop_cnt), 64'd0);

        // 4: overflow with tready low, drop racing clr_stat, then clean drain
        m_axis_tready = 1'b0;
        beats.delete();
        for (int i = 0; i < 40; i++) begin
            step((i % 2) ? 90 : 200, 200, t);
            if (i % 2) tt[i/2] = t;
        end
        repeat (6) step(200, 200, t);
        chk("t4_count", 64'(fifo_count), 64'd16);
        chk("t4_drops", 64'(drop_cnt), 64'd4);
        chk("t4_ovf",   64'(overflow), 64'd1);
        step(90, 200, t); step(200, 200, t); step(200, 200, t);
        clr_stat = 1'b1; step(200, 200, t); clr_stat = 1'b0;
        chk("t4_clr_vs_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t4_clr_vs_drop_ovf", 64'(overflow), 64'd1);
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        chk("t4_clr_cnt", 64'(drop_cnt), 64'd0);
        chk("t4_clr_ovf", 64'(overflow), 64'd0);
        m_axis_tready = 1'b1;
        repeat (20) tick();
        chk("t4_drain_cnt", 64'(beats.size()), 64'd16);
        chk("t4_first",     beat(0)[63:0], rec(0, 90, tt[0]));
        chk("t4_last",      beat(15)[63:0], rec(0, 90, tt[15]));
        chk("t4_empty",     64'(fifo_count), 64'd0);

        // 5: packet_size=4 over 10 records, final beat closed by timeout
        packet_size = 32'd4; flush_timeout = 16'd50;
        m_axis_tready = 1'b0;
        beats.delete();
        for (int i = 0; i < 20; i++) begin
            step((i % 2) ? 40 + i : 200, 200, t);
            if (i % 2) tt[i/2] = t;
        end
        repeat (5) step(200, 200, t);
        m_axis_tready = 1'b1;
        repeat (9) tick();
        m_axis_tready = 1'b0;
        chk("t5_cnt9",  64'(beats.size()), 64'd9);
        chk("t5_tlast_pattern",
            64'({beat(0)[64], beat(1)[64], beat(2)[64], beat(3)[64], beat(4)[64],
                 beat(5)[64], beat(6)[64], beat(7)[64], beat(8)[64]}), 64'b000100010);
        chk("t5_b8",    beat(8)[63:0], rec(0, 57, tt[8]));
        chk("t5_pre_valid", 64'(m_axis_tvalid), 64'd1);
        chk("t5_pre_flush", 64'(m_axis_tlast), 64'd0);
        repeat (60) tick();
        chk("t5_flush_last", 64'(m_axis_tlast), 64'd1);
        chk("t5_flush_data", m_axis_tdata, rec(0, 59, tt[9]));
        m_axis_tready = 1'b1; tick(); m_axis_tready = 1'b0;
        chk("t5_drained", 64'(m_axis_tvalid), 64'd0);

        // 6: tready 1010 during drain, reset mid-drain, packet count restarts
        flush_timeout = '0;
        beats.delete();
        for (int i = 0; i < 16; i++) begin
            step((i % 2) ? 40 + i : 200, 200, t);
            if (i % 2) tt[i/2] = t;
        end
        repeat (5) step(200, 200, t);
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = (i % 2 == 0);
            tick();
        end
        m_axis_tready = 1'b0;
        chk("t6_cnt", 64'(beats.size()), 64'd3);
        chk("t6_b0",  beat(0)[63:0], rec(0, 41, tt[0]));
        chk("t6_b1",  beat(1)[63:0], rec(0, 43, tt[1]));
        chk("t6_b2",  beat(2)[63:0], rec(0, 45, tt[2]));
        reset = 1'b1; tick();
        chk("t6_rst_valid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_rst_count", 64'(fifo_count), 64'd0);
        reset = 1'b0;
        repeat (3) step(200, 200, t);
        beats.delete();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step((i % 2) ? 40 + i : 200, 200, t);
            if (i % 2) tt[i/2] = t;
        end
        repeat (8) step(200, 200, t);
        chk("t6_post_cnt",  64'(beats.size()), 64'd4);
        chk("t6_post_b0",   beat(0)[63:0], rec(0, 41, tt[0]));
        chk("t6_post_tlast", 64'({beat(0)[64], beat(1)[64], beat(2)[64], beat(3)[64]}), 64'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
